// File: rtl/render_rect_control_if.sv
// Requester-side handshake bundle for render_rect_control: two
// valid/ready request channels, each carrying a rectangle's x, y and colour.
interface render_rect_control_if #(
    parameter int CW = 3
);
    logic          req0_valid;
    logic [6:0]    req0_x;
    logic [6:0]    req0_y;
    logic [CW-1:0] req0_colour;
    logic          req0_ready;

    logic          req1_valid;
    logic [6:0]    req1_x;
    logic [6:0]    req1_y;
    logic [CW-1:0] req1_colour;
    logic          req1_ready;

    modport master (
        output req0_valid, req0_x, req0_y, req0_colour,
        output req1_valid, req1_x, req1_y, req1_colour,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_colour,
        input  req1_valid, req1_x, req1_y, req1_colour,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/render_rect_control.sv
// Rectangle render sequencer: round-robin arbiter over two requesters, then
// drives the datapath load strobes and holds start_count for PIXELS cycles.
module render_rect_control #(
    parameter int PIXELS = 16,
    parameter int CW     = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    render_rect_control_if.slave  req,
    output logic [6:0]            data_in,
    output logic                  ld_x,
    output logic                  ld_y,
    output logic                  start_count,
    output logic [CW-1:0]         colour,
    output logic                  busy,
    output logic                  done,
    output logic                  grant
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_X = 3'd1;
    localparam logic [2:0] LOAD_Y = 3'd2;
    localparam logic [2:0] DRAW   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [7:0] LAST_PIXEL = 8'(PIXELS - 1);

    logic [2:0]    state;
    logic [7:0]    count;
    logic          last_served;
    logic [6:0]    cap_x;
    logic [6:0]    cap_y;
    logic [CW-1:0] cap_colour;

    logic any_valid;
    logic winner;
    logic accept;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    // resetn gates accept so ready is low immediately while reset is held.
    always_comb begin
        any_valid = req.req0_valid | req.req1_valid;
        winner    = (req.req0_valid && req.req1_valid) ? ~last_served : req.req1_valid;
        accept    = resetn && (state == IDLE) && any_valid;
    end

    assign req.req0_ready = accept && !winner;
    assign req.req1_ready = accept &&  winner;

    // Control state: FSM, draw counter, round-robin pointer and grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            count       <= 8'd0;
            last_served <= 1'b1;
            grant       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= LOAD_X;
                        last_served <= winner;
                        grant       <= winner;
                    end
                end
                LOAD_X: state <= LOAD_Y;
                LOAD_Y: begin
                    state <= DRAW;
                    count <= 8'd0;
                end
                DRAW: begin
                    if (count == LAST_PIXEL) begin
                        state <= DONE;
                        count <= 8'd0;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Payload capture on accept; outputs gate it by state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_x      <= winner ? req.req1_x      : req.req0_x;
            cap_y      <= winner ? req.req1_y      : req.req0_y;
            cap_colour <= winner ? req.req1_colour : req.req0_colour;
        end
    end

    // Datapath strobes and status decoded from registered state only.
    always_comb begin
        data_in     = 7'd0;
        ld_x        = 1'b0;
        ld_y        = 1'b0;
        start_count = 1'b0;
        done        = 1'b0;
        busy        = (state != IDLE);
        colour      = (state != IDLE) ? cap_colour : '0;
        case (state)
            LOAD_X: begin
                data_in = cap_x;
                ld_x    = 1'b1;
            end
            LOAD_Y: begin
                data_in = cap_y;
                ld_y    = 1'b1;
            end
            DRAW:    start_count = 1'b1;
            DONE:    done        = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_render_rect_control.sv
// Bench for render_rect_control: a cycle-timeline reference model checks every
// output each cycle; table vectors, hand sequences and random traffic drive it.
module tb_render_rect_control;
    localparam int P  = 16;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    render_rect_control_if #(.CW(CW)) ifc();

    logic [6:0]    data_in;
    logic          ld_x, ld_y, start_count, busy, done, grant;
    logic [CW-1:0] colour;

    render_rect_control #(.PIXELS(P), .CW(CW)) dut (
        .clk(clk), .resetn(resetn), .req(ifc),
        .data_in(data_in), .ld_x(ld_x), .ld_y(ld_y), .start_count(start_count),
        .colour(colour), .busy(busy), .done(done), .grant(grant)
    );

    int total = 0;
    int bad   = 0;

    // reference model: a rectangle is a timeline of offsets from its accept cycle
    int            cyc = 0;
    bit            m_act = 0;
    int            m_tacc = 0;
    logic [6:0]    m_x = '0, m_y = '0;
    logic [CW-1:0] m_c = '0;
    logic          m_g = 1'b0;
    logic          m_last = 1'b1;

    // observations
    int            acc_cyc[$];
    logic          acc_g[$];
    int            done_cnt = 0, done_cyc = 0, ldx_cnt = 0;
    logic [6:0]    seen_x, seen_y;
    logic [CW-1:0] seen_c;
    logic          seen_g;
    logic          last_r0 = 1'b0, last_r1 = 1'b0;

    typedef struct {
        logic v0, v1;
        logic [6:0] x0, y0; logic [CW-1:0] c0;
        logic [6:0] x1, y1; logic [CW-1:0] c1;
        logic eg; logic [6:0] ex, ey; logic [CW-1:0] ec;
    } vec_t;
    vec_t tbl[6];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] outv();
        return {ifc.req0_ready, ifc.req1_ready, data_in, ld_x, ld_y, start_count,
                colour, busy, done, grant};
    endfunction

    task automatic set_req(logic v0, logic [6:0] x0, logic [6:0] y0, logic [CW-1:0] c0,
                           logic v1, logic [6:0] x1, logic [6:0] y1, logic [CW-1:0] c1);
        ifc.req0_valid = v0; ifc.req0_x = x0; ifc.req0_y = y0; ifc.req0_colour = c0;
        ifc.req1_valid = v1; ifc.req1_x = x1; ifc.req1_y = y1; ifc.req1_colour = c1;
    endtask

    // One clock cycle: called after the negedge with inputs already driven.
    task automatic tick();
        int d;
        logic [17:0] e;
        logic w, v0, v1;
        #1;
        v0 = ifc.req0_valid;
        v1 = ifc.req1_valid;
        if (m_act && (cyc - m_tacc) == P + 4) m_act = 0;
        d = cyc - m_tacc;
        w = (v0 && v1) ? ~m_last : v1;
        e = '0;
        e[0] = m_g;
        if (!m_act) begin
            if (v0 || v1) begin
                e[17] = !w;
                e[16] = w;
            end
        end else begin
            e[2]   = 1'b1;
            e[5:3] = m_c;
            if (d == 1) begin e[15:9] = m_x; e[8] = 1'b1; end
            if (d == 2) begin e[15:9] = m_y; e[7] = 1'b1; end
            if (d >= 3 && d <= P + 2) e[6] = 1'b1;
            if (d == P + 3) e[1] = 1'b1;
        end
        check("cycle_outputs", 32'(outv()), 32'(e));

        last_r0 = ifc.req0_ready;
        last_r1 = ifc.req1_ready;
        if (ld_x) begin seen_x = data_in; seen_c = colour; seen_g = grant; ldx_cnt++; end
        if (ld_y) seen_y = data_in;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (last_r0 || last_r1) begin acc_cyc.push_back(cyc); acc_g.push_back(last_r1); end

        if (!m_act && (v0 || v1)) begin
            m_act  = 1;
            m_tacc = cyc;
            m_g    = w;
            m_last = w;
            m_x    = w ? ifc.req1_x      : ifc.req0_x;
            m_y    = w ? ifc.req1_y      : ifc.req0_y;
            m_c    = w ? ifc.req1_colour : ifc.req0_colour;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        resetn = 1'b0;
        #1;
        check("reset_async", 32'(outv()), 32'd0);
        m_act = 0; m_last = 1'b1; m_g = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hold", 32'(outv()), 32'd0);
        resetn = 1'b1;
    endtask

    task automatic wait_acc(int n, int lim);
        int k = 0;
        while (acc_cyc.size() < n && k < lim) begin tick(); k++; end
        check("accept_count", acc_cyc.size(), n);
    endtask

    task automatic wait_done(int d0, int lim);
        int k = 0;
        while (done_cnt <= d0 && k < lim) begin tick(); k++; end
        check("done_seen", done_cnt, d0 + 1);
    endtask

    initial begin
        int t0, d0, lx0;
        bit pend0, pend1;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);

        tbl[0] = '{1,0, 7'h2A,7'h15,3'd5, 7'h00,7'h00,3'd0, 0, 7'h2A,7'h15,3'd5};
        tbl[1] = '{1,1, 7'h01,7'h02,3'd1, 7'h11,7'h22,3'd3, 1, 7'h11,7'h22,3'd3};
        tbl[2] = '{1,1, 7'h33,7'h44,3'd6, 7'h55,7'h66,3'd2, 0, 7'h33,7'h44,3'd6};
        tbl[3] = '{0,1, 7'h00,7'h00,3'd0, 7'h7F,7'h00,3'd7, 1, 7'h7F,7'h00,3'd7};
        tbl[4] = '{0,1, 7'h00,7'h00,3'd0, 7'h00,7'h7F,3'd0, 1, 7'h00,7'h7F,3'd0};
        tbl[5] = '{1,1, 7'h12,7'h34,3'd4, 7'h56,7'h78,3'd1, 0, 7'h12,7'h34,3'd4};

        // reset then idle with no requests
        @(negedge clk);
        do_reset();
        repeat (10) tick();

        // table-driven transactions from a fresh round-robin pointer
        for (int i = 0; i < 6; i++) begin
            set_req(tbl[i].v0, tbl[i].x0, tbl[i].y0, tbl[i].c0,
                    tbl[i].v1, tbl[i].x1, tbl[i].y1, tbl[i].c1);
            acc_cyc.delete(); acc_g.delete();
            d0 = done_cnt;
            wait_acc(1, 50);
            set_req(0, 0, 0, 0, 0, 0, 0, 0);
            wait_done(d0, 40);
            check("tbl_grant",  32'(seen_g), 32'(tbl[i].eg));
            check("tbl_x",      32'(seen_x), 32'(tbl[i].ex));
            check("tbl_y",      32'(seen_y), 32'(tbl[i].ey));
            check("tbl_colour", 32'(seen_c), 32'(tbl[i].ec));
            if (acc_cyc.size() > 0) check("tbl_done_latency", done_cyc - acc_cyc[0], P + 3);
            tick();
        end

        // tie held from reset: alternating grants every PIXELS+4 cycles
        set_req(1, 7'h0A, 7'h0B, 3'd2, 1, 7'h1A, 7'h1B, 3'd6);
        do_reset();
        acc_cyc.delete(); acc_g.delete();
        wait_acc(4, 200);
        for (int i = 0; i < 4 && i < acc_cyc.size(); i++) begin
            check("tie_order", 32'(acc_g[i]), 32'(i % 2));
            if (i > 0) check("tie_interval", acc_cyc[i] - acc_cyc[i-1], P + 4);
        end
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (P + 5) tick();

        // busy blocking: req1 raised during req0's draw waits for IDLE
        set_req(1, 7'h05, 7'h06, 3'd3, 0, 0, 0, 0);
        acc_cyc.delete(); acc_g.delete();
        wait_acc(1, 30);
        t0 = (acc_cyc.size() > 0) ? acc_cyc[0] : cyc;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        while (cyc < t0 + 5) tick();
        set_req(0, 0, 0, 0, 1, 7'h41, 7'h42, 3'd4);
        wait_acc(2, 50);
        if (acc_cyc.size() > 1) begin
            check("busy_accept_cycle", acc_cyc[1], t0 + P + 4);
            check("busy_accept_who", 32'(acc_g[1]), 32'd1);
        end
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (P + 5) tick();

        // withdrawn request: one-cycle req1 pulse while busy is never served
        set_req(1, 7'h07, 7'h08, 3'd1, 0, 0, 0, 0);
        acc_cyc.delete(); acc_g.delete();
        wait_acc(1, 30);
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        lx0 = ldx_cnt;
        acc_cyc.delete(); acc_g.delete();
        set_req(0, 0, 0, 0, 1, 7'h77, 7'h66, 3'd5);
        tick();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (P + 10) tick();
        check("withdrawn_accepts", acc_cyc.size(), 0);
        check("withdrawn_ldx", ldx_cnt - lx0, 0);

        // mid-draw reset at DRAW cycle 5, then a fresh request completes
        set_req(1, 7'h19, 7'h29, 3'd7, 0, 0, 0, 0);
        acc_cyc.delete(); acc_g.delete();
        wait_acc(1, 30);
        t0 = (acc_cyc.size() > 0) ? acc_cyc[0] : cyc;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        while (cyc < t0 + 8) tick();
        check("draw_before_reset", 32'(start_count), 32'd1);
        d0 = done_cnt;
        do_reset();
        repeat (30) tick();
        check("no_done_after_reset", done_cnt, d0);
        set_req(0, 0, 0, 0, 1, 7'h3C, 7'h4D, 3'd2);
        acc_cyc.delete(); acc_g.delete();
        wait_acc(1, 30);
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        wait_done(d0, 40);
        check("post_reset_x", 32'(seen_x), 32'h3C);
        check("post_reset_y", 32'(seen_y), 32'h4D);
        check("post_reset_grant", 32'(seen_g), 32'd1);

        // randomized traffic: requesters hold until ready, sometimes withdraw
        pend0 = 0; pend1 = 0;
        for (int i = 0; i < 800; i++) begin
            if (!pend0 && $urandom_range(0, 3) == 0) begin
                pend0 = 1;
                ifc.req0_x = 7'($urandom); ifc.req0_y = 7'($urandom);
                ifc.req0_colour = CW'($urandom);
            end else if (pend0 && !busy && $urandom_range(0, 15) == 0) begin
                pend0 = 0;
            end
            if (!pend1 && $urandom_range(0, 3) == 0) begin
                pend1 = 1;
                ifc.req1_x = 7'($urandom); ifc.req1_y = 7'($urandom);
                ifc.req1_colour = CW'($urandom);
            end else if (pend1 && !busy && $urandom_range(0, 15) == 0) begin
                pend1 = 0;
            end
            ifc.req0_valid = pend0;
            ifc.req1_valid = pend1;
            tick();
            if (last_r0) pend0 = 0;
            if (last_r1) pend1 = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/render_rect_control.md
# render_rect_control

Sequencer and two-port arbiter for the rectangle render datapath. It accepts rectangle draw requests (x, y, colour) from two requesters over valid/ready handshakes and grants them round-robin. For each granted request it drives the datapath's data_in/ld_x/ld_y/start_count strobes in order, then holds the draw phase for a fixed pixel count. It sits between the game/input logic and the datapath feeding the VGA adapter.

## Interface
- PIXELS, 16: cycles start_count is held per rectangle (4x4 box); legal range 1..255
- CW, 3: colour width
- clk  in  1  system clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a rectangle pending
- req0_x  in  7  requester 0 x coordinate
- req0_y  in  7  requester 0 y coordinate
- req0_colour  in  CW  requester 0 colour
- req0_ready  out  1  requester 0 request accepted this cycle
- req1_valid, req1_x, req1_y, req1_colour, req1_ready: same as requester 0, for requester 1
- data_in  out  7  coordinate bus to datapath
- ld_x  out  1  load data_in as x
- ld_y  out  1  load data_in as y
- start_count  out  1  datapath pixel counter enable
- colour  out  CW  colour of the rectangle being drawn, to VGA
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of each rectangle
- grant  out  1  index of requester currently being served

## Operation
- States: IDLE -> LOAD_X -> LOAD_Y -> DRAW -> DONE -> IDLE.
- IDLE: if any reqN_valid, pick the winner, assert its reqN_ready combinationally this cycle, and capture x, y and colour into internal registers.
  - Set grant to the winner; go to LOAD_X.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester not served last wins.
  - The last-served pointer updates on each accept and resets to 1, so requester 0 wins the first tie.
- LOAD_X: data_in = captured x, ld_x = 1, for one cycle.
- LOAD_Y: data_in = captured y, ld_y = 1, for one cycle.
- DRAW: start_count = 1 while an internal 8-bit counter runs 0..PIXELS-1. Leave on the cycle the counter equals PIXELS-1.
- DONE: done = 1 for one cycle; return to IDLE.
- Output values:
  - data_in = 0 outside LOAD_X/LOAD_Y.
  - ld_x, ld_y and start_count are never high together.
  - colour holds the captured colour from LOAD_X through DONE and is 0 in IDLE.
- Both ready outputs are 0 in every non-IDLE state. Requests arriving while busy wait; requesters must hold valid and payload stable until ready.
- A requester dropping valid before ready is not a transaction; nothing is captured.

## Timing
- Reset (resetn = 0, asynchronous):
  - state = IDLE, counter = 0, last-served = 1.
  - data_in, ld_x, ld_y, start_count, colour, busy, done, grant and both readys = 0 immediately, without waiting for a clock.
- Reset mid-operation abandons the rectangle; there is no resume.
- Accept happens at cycle T, the IDLE cycle where ready = 1.
  - LOAD_X at T+1, LOAD_Y at T+2.
  - DRAW at T+3..T+2+PIXELS.
  - DONE at T+3+PIXELS; IDLE at T+4+PIXELS.
- The earliest next accept is T+4+PIXELS, so back-to-back rectangles take PIXELS+4 cycles each.
- busy rises at T+1 and falls after DONE.
- All outputs except reqN_ready are registered or decoded from registered state only. ready depends combinationally on valid and state.

## Test plan
- Reset/idle:
  - Stimulus: hold resetn = 0 for 3 cycles, then release with no valid.
  - Required response: all outputs 0, and they stay 0 for 10 cycles.
- Single request:
  - Stimulus: req0 with x = 0x2A, y = 0x15, colour = 3'b101, PIXELS = 16.
  - Required response: req0_ready at T; ld_x with data_in = 0x2A at T+1; ld_y with data_in = 0x15 at T+2.
  - Required response: start_count high for exactly 16 cycles (T+3..T+18); done at T+19; colour = 5 over T+1..T+19.
- Tie:
  - Stimulus: req0 and req1 both valid and held from reset.
  - Required response: grants in the order 0, 1, 0, 1.
  - Required response: each accept is exactly 20 cycles after the previous one; grant matches the requester served.
- Busy blocking:
  - Stimulus: assert req1_valid during req0's DRAW phase.
  - Required response: req1_ready stays 0 until the IDLE cycle after req0's done, then req1 is accepted.
- Mid-draw reset:
  - Stimulus: assert resetn = 0 at DRAW cycle 5.
  - Required response: start_count, busy and colour drop to 0 with no clock edge, and no done pulse follows.
  - Required response: after release, a new request completes normally.
- Withdrawn request:
  - Stimulus: pulse req1_valid for one cycle during busy, then deassert.
  - Required response: no accept and no LOAD_X for requester 1.
